// File: rtl/deserializer.sv
// Receive side of the framed serial link.
// Frame: start bit (0), WIDTH data bits, stop bit (1), one bit per clk.
// Each good word is placed in a one-entry holding register that the consumer
// drains with read_enable. Framing errors and overruns are reported as
// one-cycle pulses.
module deserializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_data_in,
  input  logic             read_enable,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_error,
  output logic             overrun
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;

  // The first data bit ends up in bit 0 (LSB first) or in bit WIDTH-1 (MSB first).
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], serial_data_in};
    end else begin : g_lsb_first
      assign shift_next = {serial_data_in, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  // Frame FSM, shift register, holding register and status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Pulses last a single cycle unless re-raised below.
      frame_error <= 1'b0;
      overrun     <= 1'b0;

      // Consumer drains the holding register; a load in STOP overrides this.
      if (read_enable && data_valid) begin
        data_valid <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (!serial_data_in) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            busy        <= 1'b1;
          end
        end

        DATA: begin
          shift_reg <= shift_next;
          if (bit_cnt_reg == LAST_BIT) begin
            state_reg <= STOP;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end

        STOP: begin
          // Always back to IDLE: a low stop bit is never reused as a start bit.
          state_reg <= IDLE;
          busy      <= 1'b0;
          if (serial_data_in) begin
            if (!data_valid || read_enable) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_error <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for deserializer: a 32-bit LSB-first instance and an
// 8-bit MSB-first instance share the clock and reset.
module tb_deserializer;

  logic        clk;
  logic        reset;

  logic        sin32;
  logic        re32;
  logic [31:0] dout32;
  logic        dv32;
  logic        busy32;
  logic        fe32;
  logic        ov32;

  logic        sin8;
  logic        re8;
  logic [7:0]  dout8;
  logic        dv8;
  logic        busy8;
  logic        fe8;
  logic        ov8;

  int total;
  int bad;

  deserializer #(.WIDTH(32), .MSB_FIRST(1'b0)) dut32 (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (sin32),
    .read_enable    (re32),
    .data_out       (dout32),
    .data_valid     (dv32),
    .busy           (busy32),
    .frame_error    (fe32),
    .overrun        (ov32)
  );

  deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
    .clk            (clk),
    .reset          (reset),
    .serial_data_in (sin8),
    .read_enable    (re8),
    .data_out       (dout8),
    .data_valid     (dv8),
    .busy           (busy8),
    .frame_error    (fe8),
    .overrun        (ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One 32-bit frame; reports busy cycles seen and data_valid just before stop.
  task automatic send32(input logic [31:0] w, input logic stop, input logic re_first,
                        input logic re_stop, output int busy_cycles, output logic valid_pre);
    busy_cycles = 0;
    sin32 = 1'b0;
    re32  = re_first;
    tick();
    re32 = 1'b0;
    if (busy32) busy_cycles++;
    for (int i = 0; i < 32; i++) begin
      sin32 = w[i];
      tick();
      if (busy32) busy_cycles++;
    end
    valid_pre = dv32;
    sin32 = stop;
    re32  = re_stop;
    tick();
    sin32 = 1'b1;
    re32  = 1'b0;
    $display("tx32 word=%h stop=%b dout=%h valid=%b fe=%b ov=%b", w, stop, dout32, dv32, fe32, ov32);
  endtask

  // One 8-bit frame; seq[7] is the first data bit on the line.
  task automatic send8(input logic [7:0] seq);
    sin8 = 1'b0;
    tick();
    for (int i = 7; i >= 0; i--) begin
      sin8 = seq[i];
      tick();
    end
    sin8 = 1'b1;
    tick();
    $display("tx8 seq=%b dout=%h valid=%b", seq, dout8, dv8);
  endtask

  task automatic read32;
    re32 = 1'b1;
    tick();
    re32 = 1'b0;
  endtask

  initial begin
    int   bc;
    logic vp;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    sin32 = 1'b1;
    re32  = 1'b0;
    sin8  = 1'b1;
    re8   = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_dout", dout32, 32'h0);
    chk("rst_valid", {31'b0, dv32}, 32'd0);
    chk("rst_busy", {31'b0, busy32}, 32'd0);
    chk("rst_fe", {31'b0, fe32}, 32'd0);
    chk("rst_ov", {31'b0, ov32}, 32'd0);
    #2 reset = 1'b1;
    tick();

    // Single frame, latency and busy length
    send32(32'hDEADBEEF, 1'b1, 1'b0, 1'b0, bc, vp);
    chk("t1_valid_pre", {31'b0, vp}, 32'd0);
    chk("t1_valid", {31'b0, dv32}, 32'd1);
    chk("t1_dout", dout32, 32'hDEADBEEF);
    chk("t1_busy_cycles", 32'(bc), 32'd33);
    chk("t1_busy_after", {31'b0, busy32}, 32'd0);
    read32();
    chk("t1_read_clear", {31'b0, dv32}, 32'd0);
    read32();
    chk("t1_read_empty", {31'b0, dv32}, 32'd0);

    // Back-to-back frames, consumer reads the first during the second start bit
    send32(32'h12345678, 1'b1, 1'b0, 1'b0, bc, vp);
    chk("t2_dout_a", dout32, 32'h12345678);
    chk("t2_valid_a", {31'b0, dv32}, 32'd1);
    send32(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, bc, vp);
    chk("t2_valid_pre_b", {31'b0, vp}, 32'd0);
    chk("t2_dout_b", dout32, 32'hCAFEF00D);
    chk("t2_valid_b", {31'b0, dv32}, 32'd1);
    chk("t2_ov", {31'b0, ov32}, 32'd0);
    chk("t2_fe", {31'b0, fe32}, 32'd0);
    read32();

    // Framing error: low stop bit, not reused as start
    send32(32'hA5A5A5A5, 1'b0, 1'b0, 1'b0, bc, vp);
    chk("t3_fe_pulse", {31'b0, fe32}, 32'd1);
    chk("t3_ov", {31'b0, ov32}, 32'd0);
    chk("t3_valid", {31'b0, dv32}, 32'd0);
    chk("t3_busy", {31'b0, busy32}, 32'd0);
    tick();
    chk("t3_fe_end", {31'b0, fe32}, 32'd0);
    chk("t3_idle", {31'b0, busy32}, 32'd0);
    send32(32'h00000001, 1'b1, 1'b0, 1'b0, bc, vp);
    chk("t3_dout_next", dout32, 32'h00000001);
    chk("t3_valid_next", {31'b0, dv32}, 32'd1);
    read32();

    // Overrun, then simultaneous read and load
    send32(32'h11111111, 1'b1, 1'b0, 1'b0, bc, vp);
    send32(32'h22222222, 1'b1, 1'b0, 1'b0, bc, vp);
    chk("t4_ov_pulse", {31'b0, ov32}, 32'd1);
    chk("t4_fe", {31'b0, fe32}, 32'd0);
    chk("t4_dout_kept", dout32, 32'h11111111);
    chk("t4_valid_kept", {31'b0, dv32}, 32'd1);
    tick();
    chk("t4_ov_end", {31'b0, ov32}, 32'd0);
    send32(32'h22222222, 1'b1, 1'b0, 1'b1, bc, vp);
    chk("t4_dout_load", dout32, 32'h22222222);
    chk("t4_valid_load", {31'b0, dv32}, 32'd1);
    chk("t4_no_ov", {31'b0, ov32}, 32'd0);
    read32();

    // Asynchronous reset in the middle of a frame, holding register full
    send32(32'h0F0F0F0F, 1'b1, 1'b0, 1'b0, bc, vp);
    sin32 = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      sin32 = 1'b1;
      tick();
    end
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_dout", dout32, 32'h0);
    chk("t5_rst_valid", {31'b0, dv32}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy32}, 32'd0);
    tick();
    chk("t5_rst_fe", {31'b0, fe32}, 32'd0);
    chk("t5_rst_ov", {31'b0, ov32}, 32'd0);
    #2 reset = 1'b1;
    sin32 = 1'b1;
    tick();
    chk("t5_idle_after", {31'b0, busy32}, 32'd0);
    send32(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, bc, vp);
    chk("t5_dout", dout32, 32'hFFFFFFFF);
    chk("t5_valid", {31'b0, dv32}, 32'd1);

    // MSB-first 8-bit instance
    send8(8'b10000001);
    chk("t6_dout_a", {24'b0, dout8}, 32'h81);
    chk("t6_valid_a", {31'b0, dv8}, 32'd1);
    re8 = 1'b1;
    tick();
    re8 = 1'b0;
    chk("t6_read_clear", {31'b0, dv8}, 32'd0);
    send8(8'b11000000);
    chk("t6_dout_b", {24'b0, dout8}, 32'hC0);
    chk("t6_valid_b", {31'b0, dv8}, 32'd1);
    chk("t6_fe", {31'b0, fe8}, 32'd0);
    chk("t6_ov", {31'b0, ov8}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive end of the serial link driven by the team's Serializer block.
- Samples one bit per clk on a framed serial line and reassembles WIDTH-bit words.
- Presents each word through a one-entry holding register with a valid/read handshake.
- Flags framing errors and overruns as single-cycle pulses for the status/debug logic.

Parameters:
WIDTH, 32, data word width in bits (must be >= 2)
MSB_FIRST, 0, 0 = first data bit received is bit 0; 1 = first data bit received is bit WIDTH-1

Ports:
clk  input  1  system clock, all sampling on rising edge
reset  input  1  asynchronous, active-low reset
serial_data_in  input  1  serial line, idles high, synchronous to clk
read_enable  input  1  consumer accepts data_out this cycle (qualified by data_valid)
data_out  output  WIDTH  last good received word
data_valid  output  1  data_out holds an unread word
busy  output  1  frame reception in progress (state != IDLE)
frame_error  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because holding register full

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, bit counter=0, shift register=0, data_out=0, data_valid=0, frame_error=0, overrun=0, busy=0. Reset mid-frame abandons the frame; no pulse is generated.
- Frame format: 1 start bit (0), WIDTH data bits, 1 stop bit (1). One bit per clk, no idle gap required between frames.
- FSM IDLE:
  - serial_data_in=0 sampled -> DATA, counter=0.
  - serial_data_in=1 -> stay in IDLE.
- FSM DATA:
  - Shift in serial_data_in each cycle; counter increments.
  - After bit WIDTH-1 is sampled -> STOP.
  - Shift direction per MSB_FIRST.
- FSM STOP, stop bit sampled:
  - stop=1 and (data_valid=0 or read_enable=1): data_out <= assembled word, data_valid <= 1.
  - stop=1, data_valid=1, read_enable=0: word discarded, data_out unchanged, overrun pulses high for one cycle.
  - stop=0: word discarded, frame_error pulses for one cycle. That 0 is NOT taken as a new start bit.
  - All STOP cases -> IDLE.
- Latency: start bit sampled at edge E0, data bits at E1..E(WIDTH), stop at E(WIDTH+1). data_valid/data_out update at E(WIDTH+1), i.e. visible WIDTH+1 cycles after the start-bit edge.
- Back-to-back frames: minimum frame period WIDTH+2 cycles. A start bit is accepted on the cycle immediately after the stop bit.
- Handshake:
  - read_enable=1 with data_valid=1 clears data_valid at the next edge.
  - read_enable with data_valid=0 is ignored.
  - Simultaneous read_enable and new word load: load wins, data_valid stays 1, data_out = new word, no overrun.
- busy: registered, high in DATA and STOP.
- frame_error and overrun are never high in the same cycle, and each is high for exactly one cycle per event.

Test Plan:
- WIDTH=32, MSB_FIRST=0: drive 0, then 0xDEADBEEF LSB first, then 1. data_out=0xDEADBEEF and data_valid=1 exactly 33 cycles after the start-bit edge. busy high for 33 cycles. Then pulse read_enable: data_valid drops next edge.
- Two back-to-back frames 0x12345678, 0xCAFEF00D with no gap, consumer reads each when valid -> both delivered in order, no overrun, no frame_error.
- Frame 0xA5A5A5A5 with stop bit=0 -> frame_error single pulse, data_valid stays 0, FSM in IDLE. A following good frame 0x00000001 is received correctly.
- Frame 0x11111111 received and left unread, then frame 0x22222222 -> overrun pulse at second stop edge, data_out remains 0x11111111. Repeat with read_enable asserted on the second stop cycle -> data_out=0x22222222, data_valid=1, no overrun.
- Assert reset low mid-data (after 10 bits) -> outputs and busy go 0 immediately, no pulses. A fresh frame 0xFFFFFFFF after release is received correctly.
- MSB_FIRST=1, WIDTH=8: send 0, bits 1,0,0,0,0,0,0,1, then 1 -> data_out=0x81. Send 0, bits 1,1,0,0,0,0,0,0, then 1 -> data_out=0xC0.
